// File: rtl/pa_mds_seq.sv
// Step sequencer for multiply / divide / multi-bit shift on the P-A ALU datapath.
// Optional divide-overflow check is compiled in with `define PA_MDS_DIV_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; all outputs low
// PREP  | operand load into AT (strob1, no ALU op); divide sign q cleared
// PH1   | phase 1 of a step: ALU select, strob1, ALU feedback captured
// PH2   | phase 2 of a step: strob2, AT shift, AC write; step counter decrements
// FIN   | one-cycle done pulse
module pa_mds_seq #(
  parameter int unsigned STEPS = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic       __clk,
  input  logic       rst_,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [3:0] shc_n,
  input  logic       abort,
  input  logic       s0,
  input  logic       carry_,
  input  logic       at15_,
  output logic       busy,
  output logic       done,
  output logic       alu_apb,
  output logic       alu_amb,
  output logic       strob1,
  output logic       strob2,
  output logic       as2,
  output logic       eat0,
  output logic       w_ac,
  output logic       ovf
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_PH1  = 3'd2,
    S_PH2  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [1:0]       OP_MUL  = 2'd0;
  localparam logic [1:0]       OP_DIV  = 2'd1;
  localparam logic [1:0]       OP_SHC  = 2'd2;
  localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(STEPS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             q_q, q_d;
  logic             s0_q, s0_d;
  logic             cy_q, cy_d;
  logic             act_q, act_d;
  logic             ovf_q, ovf_d;
  logic             is_mul, is_div;

  assign is_mul = (op_q == OP_MUL);
  assign is_div = (op_q == OP_DIV);
  assign ovf    = ovf_q;

  always_ff @(posedge __clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      q_q     <= 1'b0;
      s0_q    <= 1'b0;
      cy_q    <= 1'b0;
      act_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      q_q     <= q_d;
      s0_q    <= s0_d;
      cy_q    <= cy_d;
      act_q   <= act_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    q_d     = q_q;
    s0_d    = s0_q;
    cy_d    = cy_q;
    act_d   = act_q;
    ovf_d   = ovf_q;
    busy    = 1'b0;
    done    = 1'b0;
    alu_apb = 1'b0;
    alu_amb = 1'b0;
    strob1  = 1'b0;
    strob2  = 1'b0;
    as2     = 1'b0;
    eat0    = 1'b0;
    w_ac    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          ovf_d = 1'b0;
          // reserved op 3 runs as a zero-length shift
          if (op == OP_MUL || op == OP_DIV) cnt_d = STEPS_C;
          else if (op == OP_SHC)            cnt_d = CNT_W'(shc_n);
          else                              cnt_d = '0;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        busy    = 1'b1;
        strob1  = 1'b1;
        q_d     = 1'b0;
        state_d = (cnt_q == '0) ? S_FIN : S_PH1;
      end
      S_PH1: begin
        busy   = 1'b1;
        strob1 = 1'b1;
        if (is_mul) begin
          alu_apb = ~at15_;
        end else if (is_div) begin
          // non-restoring divide: subtract after a positive partial remainder
          alu_apb = q_q;
          alu_amb = ~q_q;
          q_d     = s0;
        end
        act_d   = alu_apb | alu_amb;
        s0_d    = s0;
        cy_d    = ~carry_;
        state_d = S_PH2;
`ifdef PA_MDS_DIV_OVF_EN
        if (is_div && cnt_q == STEPS_C && !s0) ovf_d = 1'b1;
`endif
      end
      S_PH2: begin
        busy   = 1'b1;
        strob2 = 1'b1;
        as2    = 1'b1;
        w_ac   = act_q;
        if (is_mul)      eat0 = cy_q;
        else if (is_div) eat0 = ~s0_q;
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_d == '0) ? S_FIN : S_PH1;
`ifdef PA_MDS_DIV_OVF_EN
        if (ovf_q) begin
          as2     = 1'b0;
          eat0    = 1'b0;
          w_ac    = 1'b0;
          state_d = S_FIN;
        end
`endif
      end
      S_FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      done    = 1'b0;
      state_d = S_IDLE;
    end
  end

endmodule

// File: tb/tb_pa_mds_seq.sv
// Randomized bench for pa_mds_seq: per-cycle output trace compared against a
// step-level model of the multiply/divide/shift schedule.
module tb_pa_mds_seq;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'd0;
  logic [3:0] shc_n = 4'd0;
  logic       abort = 1'b0;
  logic       s0 = 1'b0;
  logic       carry_ = 1'b1;
  logic       at15_ = 1'b1;
  logic       busy, done, alu_apb, alu_amb, strob1, strob2, as2, eat0, w_ac, ovf;
  logic [9:0] obs;

  int  n_vec = 0;
  int  n_err = 0;
  bit  exp_ovf = 1'b0;
  bit  at15_v[16];
  bit  s0_v[16];
  bit  cy_v[16];

  always #5 clk = ~clk;

  pa_mds_seq dut (
    .__clk(clk), .rst_(rst_), .start(start), .op(op), .shc_n(shc_n), .abort(abort),
    .s0(s0), .carry_(carry_), .at15_(at15_),
    .busy(busy), .done(done), .alu_apb(alu_apb), .alu_amb(alu_amb),
    .strob1(strob1), .strob2(strob2), .as2(as2), .eat0(eat0), .w_ac(w_ac), .ovf(ovf)
  );

  // {busy,done,apb,amb,strob1,strob2,as2,eat0,w_ac,ovf}
  assign obs = {busy, done, alu_apb, alu_amb, strob1, strob2, as2, eat0, w_ac, ovf};

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b (busy,done,apb,amb,s1,s2,as2,eat0,wac,ovf)", tag, got, exp);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) begin
      at15_v[i] = 1'($urandom);
      s0_v[i]   = 1'($urandom);
      cy_v[i]   = 1'($urandom);
    end
  endtask

  task automatic run_seq(input string name, input logic [1:0] opv, input logic [3:0] nv,
                         input int abort_at, input int rst_at);
    int         nsteps, last, k;
    bit         ovf_case, qp;
    logic [9:0] e;
    nsteps   = (opv <= 2'd1) ? 16 : ((opv == 2'd2) ? int'(nv) : 0);
    ovf_case = 1'b0;
`ifdef PA_MDS_DIV_OVF_EN
    if (opv == 2'd1 && !s0_v[0]) ovf_case = 1'b1;
`endif
    last = ovf_case ? 4 : 2 * nsteps + 2;
    for (int c = 0; c <= last + 1; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b1;
        op    = opv;
        shc_n = nv;
        abort = 1'($urandom);
      end else begin
        start = (c <= last) ? 1'($urandom) : 1'b0;
        op    = 2'($urandom);
        shc_n = 4'($urandom);
        abort = (c == abort_at);
      end
      k = (c - 2) / 2;
      if (c >= 2 && c % 2 == 0 && k < nsteps) begin
        at15_  = at15_v[k];
        s0     = s0_v[k];
        carry_ = cy_v[k];
      end else begin
        at15_  = 1'($urandom);
        s0     = 1'($urandom);
        carry_ = 1'($urandom);
      end
      #1;
      if (c == 1) exp_ovf = 1'b0;
      e = '0;
      if (c == 0) begin
        e[0] = exp_ovf;
      end else if (c == 1) begin
        e[9] = 1'b1;
        e[5] = 1'b1;
      end else if (c == last) begin
        e[9] = 1'b1;
        e[8] = (c != abort_at);
        e[0] = exp_ovf;
      end else if (c == last + 1) begin
        e[0] = exp_ovf;
      end else begin
        e[9] = 1'b1;
        e[0] = exp_ovf;
        if (c % 2 == 0) begin
          e[5] = 1'b1;
          if (opv == 2'd0) e[7] = ~at15_v[k];
          else if (opv == 2'd1) begin
            qp   = (k == 0) ? 1'b0 : s0_v[k-1];
            e[7] = qp;
            e[6] = ~qp;
          end
        end else if (ovf_case) begin
          e[4] = 1'b1;
        end else begin
          e[4] = 1'b1;
          e[3] = 1'b1;
          if (opv == 2'd0) begin
            e[1] = ~at15_v[k];
            e[2] = ~cy_v[k];
          end else if (opv == 2'd1) begin
            e[1] = 1'b1;
            e[2] = ~s0_v[k];
          end
        end
      end
      chk($sformatf("%s c%0d", name, c), obs, e);
      if (c == 2 && ovf_case) exp_ovf = 1'b1;
      if (c == abort_at && c >= 1 && c <= last) begin
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        chk($sformatf("%s post_abort", name), obs, {9'b0, exp_ovf});
        return;
      end
      if (c == rst_at) begin
        rst_ = 1'b0;
        #1;
        chk($sformatf("%s rst_async", name), obs, 10'b0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk($sformatf("%s rst_next", name), obs, 10'b0);
        rst_    = 1'b1;
        exp_ovf = 1'b0;
        return;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("reset", obs, 10'b0);
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    chk("idle_after_reset", obs, 10'b0);

    fill_rand();
    for (int i = 0; i < 16; i++) at15_v[i] = 1'(i % 2);
    run_seq("mul_alt", 2'd0, 4'd0, -1, -1);

    fill_rand();
    run_seq("shc5", 2'd2, 4'd5, -1, -1);
    run_seq("shc0", 2'd2, 4'd0, -1, -1);
    run_seq("op3", 2'd3, 4'd9, -1, -1);

    fill_rand();
    s0_v[0] = 1'b1; s0_v[1] = 1'b0; s0_v[2] = 1'b1;
    run_seq("div101", 2'd1, 4'd0, -1, -1);

    fill_rand();
    s0_v[0] = 1'b0;
    run_seq("div_s0first0", 2'd1, 4'd0, -1, -1);

    fill_rand();
    run_seq("mul_abort7", 2'd0, 4'd0, 14, -1);

    fill_rand();
    run_seq("mul_rst_ph2", 2'd0, 4'd0, -1, 5);

    for (int r = 0; r < 12; r++) begin
      logic [1:0] ro;
      logic [3:0] rn;
      int         ra;
      fill_rand();
      ro = 2'($urandom);
      rn = 4'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : -1;
      run_seq($sformatf("rnd%0d", r), ro, rn, ra, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
